// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU-control decoder with an optional iterative low-half multiplier.
// Build option: define ALU_CTRL_SEQ_MUL_EN to include the R-type MUL datapath and its stall state.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   S_IDLE | accepting requests; non-MUL results appear the following cycle
//   S_MUL  | multiplier retiring MUL_STEP bits of op_b per cycle; issue stalled
module alu_ctrl_seq #(
    parameter int XLEN     = 64,
    parameter int MUL_STEP = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [4:0]      Funct,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    output logic [3:0]      Operation,
    output logic            illegal,
    output logic [XLEN-1:0] mul_result
);

    if (XLEN % MUL_STEP != 0) begin : g_bad_step
        $error("XLEN must be a multiple of MUL_STEP");
    end

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;
    localparam logic [3:0] OP_SLT = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_ILL = 4'b1111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic       illegal;
        logic [3:0] op;
    } decode_t;

    function automatic decode_t decode(input logic [1:0] alu_op, input logic [4:0] funct);
        decode_t    d;
        logic [2:0] f3;
        logic       s;
        logic       m;
        f3 = funct[2:0];
        s  = funct[4];
        m  = funct[3];
        d.op      = OP_ILL;
        d.illegal = 1'b1;
        case (alu_op)
            2'b00: begin
                d.illegal = 1'b0;
                if (f3 == 3'b001)
                    d.op = OP_SLL;
                else if (f3 == 3'b101)
                    d.op = s ? OP_SRA : OP_SRL;
                else
                    d.op = OP_ADD;
            end
            2'b01: begin
                if (f3 != 3'b010 && f3 != 3'b011) begin
                    d.op      = OP_SUB;
                    d.illegal = 1'b0;
                end
            end
            2'b10: begin
                if (!m) begin
                    d.illegal = 1'b0;
                    case ({s, f3})
                        4'b0000: d.op = OP_ADD;
                        4'b1000: d.op = OP_SUB;
                        4'b0111: d.op = OP_AND;
                        4'b0110: d.op = OP_OR;
                        4'b0100: d.op = OP_XOR;
                        4'b0001: d.op = OP_SLL;
                        4'b0101: d.op = OP_SRL;
                        4'b1101: d.op = OP_SRA;
                        4'b0010: d.op = OP_SLT;
                        default: begin
                            d.op      = OP_ILL;
                            d.illegal = 1'b1;
                        end
                    endcase
                end
`ifdef ALU_CTRL_SEQ_MUL_EN
                else if (!s && f3 == 3'b000) begin
                    d.op      = OP_MUL;
                    d.illegal = 1'b0;
                end
`endif
            end
            default: ;
        endcase
        return d;
    endfunction

    state_t          state, state_next;
    logic            out_valid_next;
    logic [3:0]      op_next;
    logic            illegal_next;
    logic [XLEN-1:0] mul_result_next;
    decode_t         dec;
    logic            accept;

`ifdef ALU_CTRL_SEQ_MUL_EN
    localparam int NSTEPS = XLEN / MUL_STEP;
    localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

    // a_sh carries op_a << count*MUL_STEP, b_sh carries op_b >> count*MUL_STEP,
    // so the current chunk of op_b is always in the low bits.
    logic [XLEN-1:0] acc, acc_next;
    logic [XLEN-1:0] a_sh, a_sh_next;
    logic [XLEN-1:0] b_sh, b_sh_next;
    logic [CW-1:0]   count, count_next;
    logic [XLEN-1:0] step_term;

    assign step_term = a_sh * {{(XLEN - MUL_STEP){1'b0}}, b_sh[MUL_STEP-1:0]};
    assign in_ready  = (state == S_IDLE);
`else
    logic unused_ops;
    assign unused_ops = ^{op_a, op_b};
    assign in_ready   = 1'b1;
`endif

    assign accept = in_valid && in_ready;
    assign dec    = decode(ALUOp, Funct);

    always_comb begin
        state_next      = state;
        out_valid_next  = 1'b0;
        op_next         = Operation;
        illegal_next    = illegal;
        mul_result_next = mul_result;
`ifdef ALU_CTRL_SEQ_MUL_EN
        acc_next   = acc;
        a_sh_next  = a_sh;
        b_sh_next  = b_sh;
        count_next = count;
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef ALU_CTRL_SEQ_MUL_EN
                    if (dec.op == OP_MUL && !dec.illegal) begin
                        state_next = S_MUL;
                        acc_next   = '0;
                        a_sh_next  = op_a;
                        b_sh_next  = op_b;
                        count_next = '0;
                    end else begin
                        out_valid_next = 1'b1;
                        op_next        = dec.op;
                        illegal_next   = dec.illegal;
                    end
`else
                    out_valid_next = 1'b1;
                    op_next        = dec.op;
                    illegal_next   = dec.illegal;
`endif
                end
            end
            S_MUL: begin
`ifdef ALU_CTRL_SEQ_MUL_EN
                acc_next   = acc + step_term;
                a_sh_next  = a_sh << MUL_STEP;
                b_sh_next  = b_sh >> MUL_STEP;
                count_next = count + 1'b1;
                if (count == LAST) begin
                    state_next      = S_IDLE;
                    out_valid_next  = 1'b1;
                    op_next         = OP_MUL;
                    illegal_next    = 1'b0;
                    mul_result_next = acc + step_term;
                    count_next      = '0;
                end
`else
                state_next = S_IDLE;
`endif
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            out_valid  <= 1'b0;
            Operation  <= 4'b0000;
            illegal    <= 1'b0;
            mul_result <= '0;
`ifdef ALU_CTRL_SEQ_MUL_EN
            acc        <= '0;
            a_sh       <= '0;
            b_sh       <= '0;
            count      <= '0;
`endif
        end else begin
            state      <= state_next;
            out_valid  <= out_valid_next;
            Operation  <= op_next;
            illegal    <= illegal_next;
            mul_result <= mul_result_next;
`ifdef ALU_CTRL_SEQ_MUL_EN
            acc        <= acc_next;
            a_sh       <= a_sh_next;
            b_sh       <= b_sh_next;
            count      <= count_next;
`endif
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed cases, then random requests against a table-driven model.
// MUL expectations apply only when ALU_CTRL_SEQ_MUL_EN is defined for the build.
module tb_alu_ctrl_seq;

    localparam int XLEN   = 64;
    localparam int NSTEPS = 16;

`ifdef ALU_CTRL_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      ALUOp;
    logic [4:0]      Funct;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic [3:0]      Operation;
    logic            illegal;
    logic [XLEN-1:0] mul_result;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0]      rtab [16];
    logic [XLEN-1:0] exp_mul_last;

    alu_ctrl_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUOp      (ALUOp),
        .Funct      (Funct),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .Operation  (Operation),
        .illegal    (illegal),
        .mul_result (mul_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // R-type (m=0) operations indexed by {s,f3}; unlisted entries are illegal.
    task automatic init_table();
        for (int i = 0; i < 16; i++) rtab[i] = 4'hF;
        rtab[4'b0000] = 4'b0010;
        rtab[4'b1000] = 4'b0110;
        rtab[4'b0111] = 4'b0000;
        rtab[4'b0110] = 4'b0001;
        rtab[4'b0100] = 4'b0011;
        rtab[4'b0001] = 4'b0111;
        rtab[4'b0101] = 4'b1000;
        rtab[4'b1101] = 4'b1001;
        rtab[4'b0010] = 4'b1010;
    endtask

    task automatic model(input logic [1:0] a_op, input logic [4:0] fn,
                         output logic [3:0] op, output logic ill, output logic mul);
        int f3;
        f3  = int'(fn[2:0]);
        op  = 4'hF;
        ill = 1'b1;
        mul = 1'b0;
        if (a_op == 2'd0) begin
            ill = 1'b0;
            op  = (f3 == 1) ? 4'd7 : (f3 == 5) ? (fn[4] ? 4'd9 : 4'd8) : 4'd2;
        end else if (a_op == 2'd1) begin
            if (f3 != 2 && f3 != 3) begin
                op  = 4'd6;
                ill = 1'b0;
            end
        end else if (a_op == 2'd2) begin
            if (!fn[3]) begin
                op  = rtab[{fn[4], fn[2:0]}];
                ill = (op == 4'hF);
            end else if (MUL_EN && !fn[4] && f3 == 0) begin
                op  = 4'hC;
                ill = 1'b0;
                mul = 1'b1;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        reset_n  = 1'b0;
        in_valid = 1'b1;
        ALUOp    = 2'b10;
        Funct    = 5'b00000;
        op_a     = '0;
        op_b     = '0;
        repeat (cycles) @(posedge clk);
        #1;
        exp_mul_last = '0;
    endtask

    // Present one request, wait for its result and check it. Leaves in_valid high
    // after a non-MUL request so successive calls give back-to-back accepts.
    task automatic issue(input logic [1:0] a_op, input logic [4:0] fn,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [3:0] eop;
        logic       eill;
        logic       emul;
        model(a_op, fn, eop, eill, emul);
        check("pre_ready", in_ready, 1);
        ALUOp    = a_op;
        Funct    = fn;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (emul) begin
            ALUOp = 2'b00;
            Funct = 5'($urandom);
            op_a  = {$urandom, $urandom};
            op_b  = {$urandom, $urandom};
            for (int i = 1; i <= NSTEPS; i++) begin
                check("mul_stall_ready", in_ready, 0);
                check("mul_stall_valid", out_valid, 0);
                @(posedge clk);
                #1;
            end
            exp_mul_last = a * b;
            check("mul_valid", out_valid, 1);
            check("mul_ready", in_ready, 1);
            check("mul_op", Operation, 4'hC);
            check("mul_illegal", illegal, 0);
            check("mul_result", mul_result, exp_mul_last);
            in_valid = 1'b0;
        end else begin
            check("out_valid", out_valid, 1);
            check("operation", Operation, eop);
            check("illegal", illegal, eill);
            check("ready_kept", in_ready, 1);
            check("mul_hold", mul_result, exp_mul_last);
        end
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_no_valid", out_valid, 0);
    endtask

    initial begin
        logic [1:0]      r_op;
        logic [4:0]      r_fn;
        logic [XLEN-1:0] r_a;
        logic [XLEN-1:0] r_b;

        init_table();
        do_reset(2);
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_op", Operation, 4'b0000);
        check("rst_illegal", illegal, 0);
        check("rst_mul", mul_result, 0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_valid", out_valid, 0);

        issue(2'b10, 5'b00000, 0, 0);
        check("t2_add", Operation, 4'b0010);
        issue(2'b10, 5'b10000, 0, 0);
        check("t2_sub", Operation, 4'b0110);
        issue(2'b10, 5'b00111, 0, 0);
        check("t2_and", Operation, 4'b0000);
        idle_cycle();

        issue(2'b00, 5'b10101, 0, 0);
        check("t3_srai", Operation, 4'b1001);
        issue(2'b01, 5'b00010, 0, 0);
        check("t3_br_ill", illegal, 1);
        check("t3_br_op", Operation, 4'b1111);
        issue(2'b10, 5'b01001, 0, 0);
        check("t3_m_ill", illegal, 1);
        issue(2'b10, 5'b00100, 0, 0);
        check("t3_xor_clears_ill", illegal, 0);
        idle_cycle();

`ifdef ALU_CTRL_SEQ_MUL_EN
        issue(2'b10, 5'b01000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        check("t4_mul", mul_result, 64'hFFFF_FFFF_FFFF_FFEB);
        idle_cycle();

        ALUOp    = 2'b10;
        Funct    = 5'b01000;
        op_a     = 64'd12345;
        op_b     = 64'd678;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t5_busy", in_ready, 0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_mul_last = '0;
        check("t5_ready", in_ready, 1);
        check("t5_valid", out_valid, 0);
        for (int i = 0; i < NSTEPS + 4; i++) begin
            @(posedge clk);
            #1;
            check("t5_no_valid", out_valid, 0);
        end
`else
        issue(2'b10, 5'b01000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        check("t6_ill", illegal, 1);
        check("t6_op", Operation, 4'b1111);
        check("t6_mul_zero", mul_result, 0);
        idle_cycle();
`endif

        for (int n = 0; n < 200; n++) begin
            r_op = 2'($urandom);
            r_fn = 5'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                r_op = 2'b10;
                r_fn = 5'b01000;
            end
            r_a = {$urandom, $urandom};
            r_b = {$urandom, $urandom};
            issue(r_op, r_fn, r_a, r_b);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
